and2_stim_checker: RTL and testbench

AND2_STIM_CHECKER -- requirements
Module: and2_stim_checker

---
 rtl/and2_stim_checker.sv | 165 ++++++++++++++++
 tb/tb_and2_stim_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/and2_stim_checker.sv
// Self-checking stimulus engine for a two-input AND under test.
// Drives LFSR vectors, models the expected output and counts mismatches.
module and2_stim_checker #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             c,
  output logic             a,
  output logic             b,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam logic [15:0] SEED_L =
    (SEED == 16'h0) ? 16'hACE1 : SEED;

  // Compare index spans RUN plus DRAIN, which can exceed 16 bits.
  localparam int unsigned IDX_W = 17;

  localparam logic [IDX_W-1:0] RUN_LAST =
    IDX_W'(NUM_VECTORS - 1);
  localparam logic [IDX_W-1:0] CMP_LAST =
    IDX_W'(NUM_VECTORS + LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [15:0]        lfsr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LATENCY-1:0] exp_q;
  logic               a_q;
  logic               b_q;
  logic               dut_reset_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [CNT_W-1:0]   err_q;
  logic [CNT_W-1:0]   fei_q;

  logic [15:0]        lfsr_d;
  logic [LATENCY-1:0] exp_d;
  logic [IDX_W-1:0]   idx_d;
  logic [CNT_W-1:0]   err_d;
  logic [CNT_W-1:0]   fei_d;
  logic               cmp_en;
  logic               mismatch;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] v
  );
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  always_comb begin
    cmp_en   = (state_q == S_RUN) ||
               (state_q == S_DRAIN);
    mismatch = cmp_en && (c != exp_q[LATENCY-1]);
    lfsr_d   = lfsr_step(lfsr_q);
    exp_d    = LATENCY'({exp_q, a_q & b_q});
    idx_d    = idx_q + 1'b1;
    err_d    = err_q;
    fei_d    = fei_q;
    if (mismatch) begin
      if (err_q != CNT_MAX)
        err_d = err_q + 1'b1;
      // A zero count marks the first mismatch of this test.
      if (err_q == '0)
        fei_d = CNT_W'(idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_L;
      idx_q       <= '0;
      exp_q       <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      dut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fei_q       <= '1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          a_q         <= 1'b0;
          b_q         <= 1'b0;
          dut_reset_q <= 1'b1;
          exp_q       <= '0;
          if (start) begin
            state_q     <= S_RUN;
            lfsr_q      <= SEED_L;
            idx_q       <= '0;
            err_q       <= '0;
            fei_q       <= '1;
            a_q         <= SEED_L[0];
            b_q         <= SEED_L[1];
            dut_reset_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        S_RUN: begin
          lfsr_q <= lfsr_d;
          exp_q  <= exp_d;
          idx_q  <= idx_d;
          err_q  <= err_d;
          fei_q  <= fei_d;
          if (idx_q == RUN_LAST) begin
            state_q <= S_DRAIN;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
          end else begin
            a_q <= lfsr_d[0];
            b_q <= lfsr_d[1];
          end
        end
        S_DRAIN: begin
          exp_q <= exp_d;
          idx_q <= idx_d;
          err_q <= err_d;
          fei_q <= fei_d;
          a_q   <= 1'b0;
          b_q   <= 1'b0;
          if (idx_q == CMP_LAST) begin
            state_q     <= S_DONE;
            dut_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= (err_d == '0);
          end
        end
      endcase
    end
  end

  assign a             = a_q;
  assign b             = b_q;
  assign dut_reset     = dut_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = fei_q;

endmodule

// File: tb/tb_and2_stim_checker.sv
// Bench for and2_stim_checker: a registered-AND stand-in DUT with
// selectable c corruption, checked against a vector-list model.
module tb_and2_stim_checker;

  localparam int NV = 8;
  localparam int L  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        c;
  logic        a, b, dut_reset, busy, done, pass;
  logic [15:0] err_count, first_err_idx;
  logic        a_s, b_s, drst_s, busy_s, done_s, pass_s;
  logic [1:0]  err_s, fei_s;

  int   tests = 0;
  int   fails = 0;
  int   mode  = 0;
  logic flip  = 1'b0;
  logic g1, g2;
  logic va [NV];
  logic vb [NV];

  always #5 clk = ~clk;

  and2_stim_checker #(
    .NUM_VECTORS(NV), .LATENCY(L),
    .SEED(16'hACE1), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .c(c),
    .a(a), .b(b), .dut_reset(dut_reset),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count),
    .first_err_idx(first_err_idx)
  );

  and2_stim_checker #(
    .NUM_VECTORS(NV), .LATENCY(L),
    .SEED(16'h0000), .CNT_W(2)
  ) dut_s (
    .clk(clk), .reset(reset), .start(start), .c(c),
    .a(a_s), .b(b_s), .dut_reset(drst_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s),
    .first_err_idx(fei_s)
  );

  // Stand-in DUT: two-flop registered AND.
  always_ff @(posedge clk) begin
    if (dut_reset) begin
      g1 <= 1'b0;
      g2 <= 1'b0;
    end else begin
      g1 <= a & b;
      g2 <= g1;
    end
  end

  always_comb begin
    c = g2;
    case (mode)
      1:       c = 1'b0;
      2:       c = 1'b1;
      3:       c = ~g2;
      4:       c = g2 ^ flip;
      default: c = g2;
    endcase
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic build_vectors();
    int unsigned l;
    int unsigned fb;
    l = 32'hACE1;
    for (int n = 0; n < NV; n++) begin
      va[n] = l[0];
      vb[n] = l[1];
      fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      l = (l >> 1) | (fb << 15);
    end
  endtask

  task automatic run_test(input int m, input bit mid);
    logic ch [NV+L];
    logic ea, eb, ec;
    int   e, fe, es;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NV + L; k++) begin
      if (k > 0) @(negedge clk);
      flip  = ($urandom_range(0, 3) == 0);
      start = mid && (k == 3);
      #1;
      ch[k] = c;
      ea = (k < NV) ? va[k] : 1'b0;
      eb = (k < NV) ? vb[k] : 1'b0;
      chk("ab", {a, b}, {ea, eb});
      chk("ab_seed0", {a_s, b_s}, {ea, eb});
      chk("busy_run", {busy, done, pass, dut_reset}, 4'b1000);
      if (k == 0) begin
        chk("start_err_clr", err_count, 0);
        chk("start_fei_set", first_err_idx, 16'hffff);
      end
    end
    start = 1'b0;
    e  = 0;
    fe = -1;
    for (int k = 0; k < NV + L; k++) begin
      ec = (k >= L) ? (va[k-L] & vb[k-L]) : 1'b0;
      if (ch[k] !== ec) begin
        if (fe < 0) fe = k;
        e++;
      end
    end
    es = (e > 3) ? 3 : e;
    @(negedge clk);
    #1;
    chk("done_state", {busy, done, dut_reset}, 3'b011);
    chk("pass", pass, (e == 0));
    chk("err_count", err_count, e);
    chk("first_err_idx", first_err_idx,
        (fe < 0) ? 16'hffff : fe);
    chk("sat_done", {done_s, pass_s}, {1'b1, e == 0});
    chk("sat_err", err_s, es);
    chk("sat_fei", fei_s, (fe < 0) ? 3 : (fe & 3));
  endtask

  task automatic abort_test();
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_state", {busy, done, pass, dut_reset}, 4'b0001);
    chk("abort_ab", {a, b}, 2'b00);
    chk("abort_err", err_count, 0);
    chk("abort_fei", first_err_idx, 16'hffff);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_done", done, 0);
  endtask

  initial begin
    build_vectors();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", {busy, done, pass, dut_reset}, 4'b0001);
    chk("rst_ab", {a, b}, 2'b00);
    chk("rst_err", err_count, 0);
    chk("rst_fei", first_err_idx, 16'hffff);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_hold", {busy, done}, 2'b00);
    run_test(0, 1'b0);
    run_test(1, 1'b0);
    run_test(2, 1'b1);
    run_test(3, 1'b0);
    run_test(4, 1'b0);
    for (int i = 0; i < 4; i++)
      run_test(int'($urandom_range(0, 4)), 1'b0);
    abort_test();
    run_test(0, 1'b0);
    run_test(4, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
